// File: rtl/line_endpoint_stager.sv
// line_endpoint_stager: shadows upstream line endpoints and commits them to the sprite at each frame boundary (optional LINE_SMOOTH_EN averaging)
module line_endpoint_stager #(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] x1_in,
  input  logic [9:0]  y1_in,
  input  logic [10:0] x2_in,
  input  logic [9:0]  y2_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [10:0] x1_out,
  output logic [9:0]  y1_out,
  output logic [10:0] x2_out,
  output logic [9:0]  y2_out,
  output logic        line_active_out,
  output logic        sprite_rst_out
);
  localparam int SW = $clog2(TIMEOUT_FRAMES + 2);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state;
  logic [10:0] sx1, sx2, nx1, nx2;
  logic [9:0] sy1, sy2, ny1, ny2;
  logic [SW-1:0] stale, stale_inc;
  logic boundary, degen;
  assign ready_out = state == EMPTY;
  assign boundary = hcount_in == 11'd0 && vcount_in == 10'(V_ACTIVE);
  assign stale_inc = stale == SW'(TIMEOUT_FRAMES) ? stale : stale + 1'b1;
`ifdef LINE_SMOOTH_EN
  logic primed;
  logic [11:0] ax1, ax2;
  logic [10:0] ay1, ay2;
  assign ax1 = {1'b0, x1_out} + {1'b0, sx1} + 12'd1;
  assign ax2 = {1'b0, x2_out} + {1'b0, sx2} + 12'd1;
  assign ay1 = {1'b0, y1_out} + {1'b0, sy1} + 11'd1;
  assign ay2 = {1'b0, y2_out} + {1'b0, sy2} + 11'd1;
  assign nx1 = primed ? ax1[11:1] : sx1;
  assign nx2 = primed ? ax2[11:1] : sx2;
  assign ny1 = primed ? ay1[10:1] : sy1;
  assign ny2 = primed ? ay2[10:1] : sy2;
`else
  assign nx1 = sx1;
  assign nx2 = sx2;
  assign ny1 = sy1;
  assign ny2 = sy2;
`endif
  assign degen = nx1 == nx2 && ny1 == ny2;
  // shadow capture, boundary commit, stale tracking and sprite resync pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= EMPTY;
      {sx1, sy1, sx2, sy2} <= '0;
      {x1_out, y1_out, x2_out, y2_out} <= '0;
      line_active_out <= 1'b0;
      sprite_rst_out <= 1'b0;
      stale <= '0;
`ifdef LINE_SMOOTH_EN
      primed <= 1'b0;
`endif
    end else begin
      sprite_rst_out <= boundary;
      if (state == EMPTY && valid_in) begin
        sx1 <= x1_in > X_MAX ? X_MAX : x1_in;
        sx2 <= x2_in > X_MAX ? X_MAX : x2_in;
        sy1 <= y1_in > Y_MAX ? Y_MAX : y1_in;
        sy2 <= y2_in > Y_MAX ? Y_MAX : y2_in;
        state <= HELD;
      end
      if (boundary && state == HELD) begin
        {x1_out, y1_out, x2_out, y2_out} <= {nx1, ny1, nx2, ny2};
        line_active_out <= !degen;
        stale <= '0;
        state <= EMPTY;
`ifdef LINE_SMOOTH_EN
        primed <= 1'b1;
`endif
      end else if (boundary) begin
        stale <= stale_inc;
        if (TIMEOUT_FRAMES != 0 && stale_inc == SW'(TIMEOUT_FRAMES)) begin
          line_active_out <= 1'b0;
`ifdef LINE_SMOOTH_EN
          primed <= 1'b0;
`endif
        end
      end
    end
  end
endmodule
